// File: rtl/cpu_pipeline.sv
// Five-stage in-order MIPS-subset pipeline with forwarding, load-use stall and ID-stage branches.
// Submodule instance names are fixed so benches can preload and inspect state hierarchically.

module cpu_pc (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        en_i,
  input  logic [31:0] pc_d_i,
  output logic [31:0] pc_o
);
  logic [31:0] pc_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pc_q <= '0;
    end else if (en_i) begin
      pc_q <= pc_d_i;
    end
  end

  assign pc_o = pc_q;
endmodule

module cpu_regfile (
  input  logic        clk_i,
  input  logic        we_i,
  input  logic [4:0]  waddr_i,
  input  logic [31:0] wdata_i,
  input  logic [4:0]  raddr_a_i,
  input  logic [4:0]  raddr_b_i,
  output logic [31:0] rdata_a_o,
  output logic [31:0] rdata_b_o
);
  logic [31:0] register [0:31];

  always_ff @(posedge clk_i) begin
    if (we_i && waddr_i != 5'd0) begin
      register[waddr_i] <= wdata_i;
    end
  end

  // Same-cycle WB bypass so ID never sees a stale value.
  always_comb begin
    rdata_a_o = register[raddr_a_i];
    if (raddr_a_i == 5'd0) rdata_a_o = '0;
    else if (we_i && waddr_i == raddr_a_i) rdata_a_o = wdata_i;
    rdata_b_o = register[raddr_b_i];
    if (raddr_b_i == 5'd0) rdata_b_o = '0;
    else if (we_i && waddr_i == raddr_b_i) rdata_b_o = wdata_i;
  end
endmodule

module cpu_imem #(
  parameter int unsigned Words = 256
) (
  input  logic [$clog2(Words)-1:0] addr_i,
  output logic [31:0]              instr_o
);
  logic [31:0] memory [0:Words-1];

  assign instr_o = memory[addr_i];
endmodule

module cpu_dmem #(
  parameter int unsigned Bytes = 32
) (
  input  logic                     clk_i,
  input  logic                     we_i,
  input  logic [$clog2(Bytes)-1:0] addr_i,
  input  logic [31:0]              wdata_i,
  output logic [31:0]              rdata_o
);
  localparam int unsigned Aw = $clog2(Bytes);

  logic [7:0]    memory [0:Bytes-1];
  logic [Aw-1:0] addr1, addr2, addr3;

  assign addr1 = addr_i + Aw'(1);
  assign addr2 = addr_i + Aw'(2);
  assign addr3 = addr_i + Aw'(3);

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      memory[addr_i] <= wdata_i[7:0];
      memory[addr1]  <= wdata_i[15:8];
      memory[addr2]  <= wdata_i[23:16];
      memory[addr3]  <= wdata_i[31:24];
    end
  end

  assign rdata_o = {memory[addr3], memory[addr2], memory[addr1], memory[addr_i]};
endmodule

module cpu_pipeline #(
  parameter int unsigned IMEM_WORDS = 256,
  parameter int unsigned DMEM_BYTES = 32
) (
  input logic clk_i,
  input logic rst_i,
  input logic start_i
);
  localparam int unsigned Iaw = $clog2(IMEM_WORDS);
  localparam int unsigned Daw = $clog2(DMEM_BYTES);

  localparam logic [5:0] OpRType = 6'h00, OpAddi = 6'h08, OpLw = 6'h23;
  localparam logic [5:0] OpSw = 6'h2B, OpBeq = 6'h04, OpJ = 6'h02;
  localparam logic [5:0] FnAdd = 6'h20, FnSub = 6'h22, FnAnd = 6'h24, FnOr = 6'h25;
  localparam logic [5:0] FnMul = 6'h18;
  localparam logic [2:0] AluAdd = 3'd0, AluSub = 3'd1, AluAnd = 3'd2, AluOr = 3'd3;
  localparam logic [2:0] AluMul = 3'd4;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc4;
  } if_id_t;

  typedef struct packed {
    logic        regwrite;
    logic        memread;
    logic        memwrite;
    logic        alusrc;
    logic [2:0]  aluop;
    logic [4:0]  wreg;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] imm;
  } id_ex_t;

  typedef struct packed {
    logic        regwrite;
    logic        memread;
    logic        memwrite;
    logic [4:0]  wreg;
    logic [31:0] alu;
    logic [31:0] sdata;
  } ex_mem_t;

  typedef struct packed {
    logic        regwrite;
    logic [4:0]  wreg;
    logic [31:0] data;
  } mem_wb_t;

  if_id_t  if_id_q, if_id_d;
  id_ex_t  id_ex_q, id_ex_d, dec;
  ex_mem_t ex_mem_q, ex_mem_d;
  mem_wb_t mem_wb_q, mem_wb_d;

  logic [31:0] pc, pc_plus4, pc_next, if_instr;
  logic [31:0] rs_val, rt_val, br_a, br_b, br_target, j_target, target;
  logic [31:0] ex_a, ex_b, ex_opb, alu, dmem_rdata;
  logic [5:0]  id_op, id_funct;
  logic [4:0]  id_rs, id_rt, id_rd;
  logic        id_branch, id_jump, load_use, br_hazard, stall, front_hold, taken;
  logic        wb_we;
  logic [4:0]  wb_waddr;
  logic [31:0] wb_wdata;

  // IF
  cpu_pc PC (
    .clk_i  (clk_i),
    .rst_ni (rst_i),
    .en_i   (!front_hold),
    .pc_d_i (pc_next),
    .pc_o   (pc)
  );

  cpu_imem #(.Words(IMEM_WORDS)) Instruction_Memory (
    .addr_i  (pc[Iaw+1:2]),
    .instr_o (if_instr)
  );

  assign pc_plus4 = pc + 32'd4;
  assign pc_next  = taken ? target : pc_plus4;

  // ID
  assign id_op    = if_id_q.instr[31:26];
  assign id_rs    = if_id_q.instr[25:21];
  assign id_rt    = if_id_q.instr[20:16];
  assign id_rd    = if_id_q.instr[15:11];
  assign id_funct = if_id_q.instr[5:0];

  cpu_regfile Registers (
    .clk_i     (clk_i),
    .we_i      (wb_we),
    .waddr_i   (wb_waddr),
    .wdata_i   (wb_wdata),
    .raddr_a_i (id_rs),
    .raddr_b_i (id_rt),
    .rdata_a_o (rs_val),
    .rdata_b_o (rt_val)
  );

  always_comb begin
    dec        = '0;
    dec.rs     = id_rs;
    dec.rt     = id_rt;
    dec.wreg   = id_rt;
    dec.a      = rs_val;
    dec.b      = rt_val;
    dec.imm    = {{16{if_id_q.instr[15]}}, if_id_q.instr[15:0]};
    id_branch  = 1'b0;
    id_jump    = 1'b0;
    case (id_op)
      OpRType: begin
        dec.wreg     = id_rd;
        dec.regwrite = 1'b1;
        case (id_funct)
          FnAdd:   dec.aluop = AluAdd;
          FnSub:   dec.aluop = AluSub;
          FnAnd:   dec.aluop = AluAnd;
          FnOr:    dec.aluop = AluOr;
          FnMul:   dec.aluop = AluMul;
          default: dec.regwrite = 1'b0;
        endcase
      end
      OpAddi: begin
        dec.regwrite = 1'b1;
        dec.alusrc   = 1'b1;
      end
      OpLw: begin
        dec.regwrite = 1'b1;
        dec.memread  = 1'b1;
        dec.alusrc   = 1'b1;
      end
      OpSw: begin
        dec.memwrite = 1'b1;
        dec.alusrc   = 1'b1;
      end
      OpBeq:   id_branch = 1'b1;
      OpJ:     id_jump   = 1'b1;
      default: ;
    endcase
  end

  // Branch operands may only come from a completed ALU result in EX/MEM.
  always_comb begin
    br_a = rs_val;
    br_b = rt_val;
    if (ex_mem_q.regwrite && !ex_mem_q.memread && ex_mem_q.wreg != 5'd0) begin
      if (ex_mem_q.wreg == id_rs) br_a = ex_mem_q.alu;
      if (ex_mem_q.wreg == id_rt) br_b = ex_mem_q.alu;
    end
  end

  assign load_use = id_ex_q.memread && id_ex_q.rt != 5'd0 &&
                    (id_ex_q.rt == id_rs || id_ex_q.rt == id_rt);
  assign br_hazard = id_branch &&
      ((id_ex_q.regwrite && id_ex_q.wreg != 5'd0 &&
        (id_ex_q.wreg == id_rs || id_ex_q.wreg == id_rt)) ||
       (ex_mem_q.memread && ex_mem_q.wreg != 5'd0 &&
        (ex_mem_q.wreg == id_rs || ex_mem_q.wreg == id_rt)));
  assign stall      = load_use || br_hazard;
  assign front_hold = stall || !start_i;
  assign taken      = !front_hold && ((id_branch && br_a == br_b) || id_jump);

  assign br_target = if_id_q.pc4 + {dec.imm[29:0], 2'b00};
  assign j_target  = {if_id_q.pc4[31:28], if_id_q.instr[25:0], 2'b00};
  assign target    = id_jump ? j_target : br_target;

  assign if_id_d = front_hold ? if_id_q : (taken ? '0 : {if_instr, pc_plus4});
  assign id_ex_d = front_hold ? '0 : dec;

  // EX: EX/MEM has priority over MEM/WB; r0 is never forwarded.
  always_comb begin
    ex_a = id_ex_q.a;
    ex_b = id_ex_q.b;
    if (ex_mem_q.regwrite && ex_mem_q.wreg != 5'd0 && ex_mem_q.wreg == id_ex_q.rs) begin
      ex_a = ex_mem_q.alu;
    end else if (mem_wb_q.regwrite && mem_wb_q.wreg != 5'd0 && mem_wb_q.wreg == id_ex_q.rs) begin
      ex_a = mem_wb_q.data;
    end
    if (ex_mem_q.regwrite && ex_mem_q.wreg != 5'd0 && ex_mem_q.wreg == id_ex_q.rt) begin
      ex_b = ex_mem_q.alu;
    end else if (mem_wb_q.regwrite && mem_wb_q.wreg != 5'd0 && mem_wb_q.wreg == id_ex_q.rt) begin
      ex_b = mem_wb_q.data;
    end
  end

  assign ex_opb = id_ex_q.alusrc ? id_ex_q.imm : ex_b;

  always_comb begin
    case (id_ex_q.aluop)
      AluSub:  alu = ex_a - ex_opb;
      AluAnd:  alu = ex_a & ex_opb;
      AluOr:   alu = ex_a | ex_opb;
      AluMul:  alu = ex_a * ex_opb;
      default: alu = ex_a + ex_opb;
    endcase
  end

  always_comb begin
    ex_mem_d          = '0;
    ex_mem_d.regwrite = id_ex_q.regwrite;
    ex_mem_d.memread  = id_ex_q.memread;
    ex_mem_d.memwrite = id_ex_q.memwrite;
    ex_mem_d.wreg     = id_ex_q.wreg;
    ex_mem_d.alu      = alu;
    ex_mem_d.sdata    = ex_b;
  end

  // MEM
  cpu_dmem #(.Bytes(DMEM_BYTES)) DataMemory (
    .clk_i   (clk_i),
    .we_i    (ex_mem_q.memwrite),
    .addr_i  (ex_mem_q.alu[Daw-1:0]),
    .wdata_i (ex_mem_q.sdata),
    .rdata_o (dmem_rdata)
  );

  always_comb begin
    mem_wb_d          = '0;
    mem_wb_d.regwrite = ex_mem_q.regwrite;
    mem_wb_d.wreg     = ex_mem_q.wreg;
    mem_wb_d.data     = ex_mem_q.memread ? dmem_rdata : ex_mem_q.alu;
  end

  // WB
  assign wb_we    = mem_wb_q.regwrite;
  assign wb_waddr = mem_wb_q.wreg;
  assign wb_wdata = mem_wb_q.data;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      if_id_q  <= '0;
      id_ex_q  <= '0;
      ex_mem_q <= '0;
      mem_wb_q <= '0;
    end else begin
      if_id_q  <= if_id_d;
      id_ex_q  <= id_ex_d;
      ex_mem_q <= ex_mem_d;
      mem_wb_q <= mem_wb_d;
    end
  end
endmodule

// File: tb/tb_cpu_pipeline.sv
// Scoreboard bench for cpu_pipeline: each program pushes its expected writebacks (reg, value,
// cycle slot); a monitor pops and compares on every register-file write.

module tb_cpu_pipeline;
  logic clk_i   = 1'b0;
  logic rst_i   = 1'b1;
  logic start_i = 1'b0;

  always #5 clk_i = ~clk_i;

  cpu_pipeline dut (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .start_i (start_i)
  );

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] val;
    int          slot;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] prog[$];
  logic [7:0]  dinit [0:31];
  int          n_checks = 0;
  int          n_errors = 0;
  int          cyc      = 0;
  int          stalls   = 0;
  logic [31:0] prev_pc  = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, required %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  function automatic logic [31:0] enc_r(input logic [5:0] fn, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [4:0] rd);
    return {6'h00, rs, rt, rd, 5'd0, fn};
  endfunction

  task automatic expect_wb(input logic [4:0] rd, input logic [31:0] val, input int slot);
    exp_t e;
    e.rd   = rd;
    e.val  = val;
    e.slot = slot;
    sb.push_back(e);
  endtask

  // slot = clock edges since reset release at the sampling negedge before the write edge
  task automatic monitor();
    exp_t e;
    forever begin
      @(negedge clk_i);
      if (!rst_i) begin
        cyc     = 0;
        stalls  = 0;
        prev_pc = '0;
      end else begin
        cyc++;
        if (dut.PC.pc_o == prev_pc) stalls++;
        prev_pc = dut.PC.pc_o;
        if (dut.wb_we && dut.wb_waddr != 5'd0) begin
          if (sb.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL wb_unexpected: got r%0d <= %h at slot %0d, required no writeback",
                     dut.wb_waddr, dut.wb_wdata, cyc);
          end else begin
            e = sb.pop_front();
            check("wb_rd", 32'(dut.wb_waddr), 32'(e.rd));
            check("wb_val", dut.wb_wdata, e.val);
            check("wb_slot", 32'(cyc), 32'(e.slot));
          end
        end
      end
    end
  endtask

  task automatic load_mem();
    for (int i = 0; i < 256; i++) begin
      dut.Instruction_Memory.memory[i] <= (i < prog.size()) ? prog[i] : 32'h0;
    end
    for (int i = 0; i < 32; i++) begin
      dut.Registers.register[i] <= 32'h0;
      dut.DataMemory.memory[i]  <= dinit[i];
    end
  endtask

  task automatic run_prog(input int ncyc, input int exp_stalls);
    rst_i   = 1'b0;
    start_i = 1'b0;
    #1;
    load_mem();
    @(negedge clk_i);
    #1;
    start_i = 1'b1;
    rst_i   = 1'b1;
    repeat (ncyc) @(negedge clk_i);
    #1;
    check("sb_drained", 32'(sb.size()), 32'd0);
    check("stall_cycles", 32'(stalls), 32'(exp_stalls));
    sb.delete();
  endtask

  initial begin
    fork
      monitor();
    join_none
    for (int i = 0; i < 32; i++) dinit[i] = 8'h00;

    // Reset and idle with an all-NOP program
    prog.delete();
    #1 rst_i = 1'b0;
    load_mem();
    #1 check("pc_reset", dut.PC.pc_o, 32'd0);
    @(negedge clk_i);
    #1 rst_i = 1'b1;
    repeat (3) begin
      @(negedge clk_i);
      #1 check("pc_idle", dut.PC.pc_o, 32'd0);
    end
    start_i = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk_i);
      #1 check("pc_run", dut.PC.pc_o, 32'(4 * k));
    end

    // ALU with back-to-back forwarding
    prog.delete();
    prog.push_back(enc_i(6'h08, 5'd0, 5'd8, 16'd5));
    prog.push_back(enc_i(6'h08, 5'd8, 5'd9, 16'd3));
    prog.push_back(enc_r(6'h22, 5'd9, 5'd8, 5'd10));
    prog.push_back(enc_r(6'h18, 5'd9, 5'd10, 5'd11));
    expect_wb(5'd8, 32'd5, 4);
    expect_wb(5'd9, 32'd8, 5);
    expect_wb(5'd10, 32'd3, 6);
    expect_wb(5'd11, 32'd24, 7);
    run_prog(14, 0);
    check("alu_r11", dut.Registers.register[11], 32'd24);
    check("alu_r10", dut.Registers.register[10], 32'd3);

    // Store with forwarded data, then load back
    prog.delete();
    prog.push_back(enc_i(6'h08, 5'd0, 5'd8, 16'hFFF9));
    prog.push_back(enc_i(6'h2B, 5'd0, 5'd8, 16'd4));
    prog.push_back(enc_i(6'h23, 5'd0, 5'd9, 16'd4));
    expect_wb(5'd8, 32'hFFFF_FFF9, 4);
    expect_wb(5'd9, 32'hFFFF_FFF9, 6);
    run_prog(14, 0);
    check("mem_b4", 32'(dut.DataMemory.memory[4]), 32'h0000_00F9);
    check("mem_b5", 32'(dut.DataMemory.memory[5]), 32'h0000_00FF);
    check("mem_b6", 32'(dut.DataMemory.memory[6]), 32'h0000_00FF);
    check("mem_b7", 32'(dut.DataMemory.memory[7]), 32'h0000_00FF);
    check("mem_b3", 32'(dut.DataMemory.memory[3]), 32'h0000_0000);

    // Load-use: one stall
    dinit[0] = 8'h0A;
    prog.delete();
    prog.push_back(enc_i(6'h23, 5'd0, 5'd8, 16'd0));
    prog.push_back(enc_r(6'h20, 5'd8, 5'd8, 5'd9));
    expect_wb(5'd8, 32'd10, 4);
    expect_wb(5'd9, 32'd20, 6);
    run_prog(14, 1);
    check("lu_r9", dut.Registers.register[9], 32'd20);
    dinit[0] = 8'h00;

    // Taken beq: one stall for the operand, one flushed slot
    prog.delete();
    prog.push_back(enc_i(6'h08, 5'd0, 5'd8, 16'd1));
    prog.push_back(enc_i(6'h04, 5'd8, 5'd8, 16'd1));
    prog.push_back(enc_i(6'h08, 5'd0, 5'd9, 16'd99));
    prog.push_back(enc_i(6'h08, 5'd0, 5'd10, 16'd2));
    expect_wb(5'd8, 32'd1, 4);
    expect_wb(5'd10, 32'd2, 8);
    run_prog(14, 1);
    check("beq_r9", dut.Registers.register[9], 32'd0);
    check("beq_r10", dut.Registers.register[10], 32'd2);

    // Not-taken beq: no flush
    prog.delete();
    prog.push_back(enc_i(6'h08, 5'd0, 5'd8, 16'd1));
    prog.push_back(enc_i(6'h04, 5'd8, 5'd0, 16'd1));
    prog.push_back(enc_i(6'h08, 5'd0, 5'd9, 16'd99));
    prog.push_back(enc_i(6'h08, 5'd0, 5'd10, 16'd2));
    expect_wb(5'd8, 32'd1, 4);
    expect_wb(5'd9, 32'd99, 7);
    expect_wb(5'd10, 32'd2, 8);
    run_prog(14, 1);
    check("bnt_r9", dut.Registers.register[9], 32'd99);

    // Jump to 0x10 skipping the instruction at 0x0C
    prog.delete();
    prog.push_back(enc_i(6'h08, 5'd0, 5'd8, 16'd1));
    prog.push_back(enc_i(6'h08, 5'd0, 5'd9, 16'd2));
    prog.push_back({6'h02, 26'd4});
    prog.push_back(enc_i(6'h08, 5'd0, 5'd10, 16'd99));
    prog.push_back(enc_i(6'h08, 5'd0, 5'd11, 16'd7));
    expect_wb(5'd8, 32'd1, 4);
    expect_wb(5'd9, 32'd2, 5);
    expect_wb(5'd11, 32'd7, 8);
    run_prog(16, 0);
    check("j_r10", dut.Registers.register[10], 32'd0);
    check("j_r11", dut.Registers.register[11], 32'd7);
    check("pc_before_rst", dut.PC.pc_o, 32'd64);

    // Async reset mid-cycle, well before the next rising edge
    #2 rst_i = 1'b0;
    #1 check("pc_async_rst", dut.PC.pc_o, 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
